// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter: write FIFO feeding a clken-paced frame serialiser
module uart_tx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                        clk_50m,
    input  logic                        rst_n,
    input  logic                        clken,
    input  logic [DATA_BITS-1:0]        data_in,
    input  logic                        wr_en,
    output logic                        tx,
    output logic                        tx_busy,
    output logic                        tx_full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);
    localparam logic          ODD       = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count_n;
    logic                 wr_accept, pop;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [1:0]           stop_cnt, stop_n;
    logic                 par, par_n, tx_n;

    // A pop in the same cycle never frees space for a write to a full FIFO.
    assign wr_accept = wr_en && (fifo_count != DEPTH_C);
    assign tx_busy   = (state != IDLE);

    always_ff @(posedge clk_50m) begin
        if (wr_accept) mem[wr_ptr] <= data_in;
    end

    always_comb begin
        count_n = fifo_count;
        if (wr_accept && !pop)      count_n = fifo_count + CW'(1);
        else if (!wr_accept && pop) count_n = fifo_count - CW'(1);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_full    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)       rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= count_n;
            tx_full    <= (count_n == DEPTH_C);
            overflow   <= wr_en && !wr_accept;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            par      <= 1'b0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            shift    <= shift_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            par      <= par_n;
        end
    end

    // Parity is computed from the whole payload at pop time, so the shifter can consume it LSB-first.
    always_comb begin
        state_n = state;
        tx_n    = tx;
        shift_n = shift;
        bit_n   = bit_cnt;
        stop_n  = stop_cnt;
        par_n   = par;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    par_n   = (^mem[rd_ptr]) ^ ODD;
                    bit_n   = '0;
                    stop_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (clken) begin
                    tx_n    = 1'b0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (clken) begin
                    tx_n    = shift[0];
                    shift_n = shift >> 1;
                    bit_n   = bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) state_n = (PARITY_MODE != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (clken) begin
                    tx_n    = par;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (clken) begin
                    tx_n   = 1'b1;
                    stop_n = stop_cnt + 2'd1;
                    if (stop_cnt == LAST_STOP) state_n = IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (8N1, 8E2 and 8O1 instances)
module tb_uart_tx_fifo;
    typedef struct {
        int         inst;
        logic [7:0] data;
    } exp_t;

    logic       clk_50m;
    logic       rst_n;
    logic       clken;
    logic [7:0] din  [3];
    logic       wen  [3];
    logic       txv  [3];
    logic       busy [3];
    logic       full [3];
    logic       ovf  [3];
    logic [2:0] cnt  [3];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic ck_d;
    logic rst_prev;
    logic txp      [3];
    int   ph       [3];
    int   bc       [3];
    int   gap      [3];
    int   frames   [3];
    int   ovf_cnt  [3];
    logic [7:0] rx [3];
    logic last_par [3];
    logic chk_gap  [3];
    logic had_prev [3];

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_MODE(0), .STOP_BITS(1)) u_dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .data_in(din[0]), .wr_en(wen[0]),
        .tx(txv[0]), .tx_busy(busy[0]), .tx_full(full[0]), .fifo_count(cnt[0]), .overflow(ovf[0]));

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_MODE(1), .STOP_BITS(2)) u_even (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .data_in(din[1]), .wr_en(wen[1]),
        .tx(txv[1]), .tx_busy(busy[1]), .tx_full(full[1]), .fifo_count(cnt[1]), .overflow(ovf[1]));

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .PARITY_MODE(2), .STOP_BITS(1)) u_odd (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .data_in(din[2]), .wr_en(wen[2]),
        .tx(txv[2]), .tx_busy(busy[2]), .tx_full(full[2]), .fifo_count(cnt[2]), .overflow(ovf[2]));

    function automatic int par_of(input int i);
        return i;
    endfunction

    function automatic int stops_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    initial begin
        clk_50m = 1'b0;
        forever #5 clk_50m = ~clk_50m;
    end

    initial begin
        clken = 1'b0;
        forever begin
            repeat (15) @(negedge clk_50m);
            clken = 1'b1;
            @(negedge clk_50m);
            clken = 1'b0;
        end
    end

    always @(posedge clk_50m) ck_d <= clken;

    task automatic finish_frame(input int i);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected inst %0d: got 0x%02h, scoreboard empty", i, rx[i]);
        end else begin
            e = sb.pop_front();
            if (e.inst != i || e.data !== rx[i]) begin
                errors++;
                $display("FAIL frame_data inst %0d: got 0x%02h, expected 0x%02h from inst %0d", i, rx[i], e.data, e.inst);
            end
        end
        frames[i]++;
        had_prev[i] = 1'b1;
        gap[i] = 0;
        ph[i] = 0;
    endtask

    // Frame decoder: one line sample per clken, taken on the falling edge after it.
    initial begin
        rst_prev = 1'b0;
        for (int i = 0; i < 3; i++) begin
            txp[i] = 1'b1; ph[i] = 0; bc[i] = 0; gap[i] = 0; frames[i] = 0; ovf_cnt[i] = 0;
            rx[i] = '0; last_par[i] = 1'b0; chk_gap[i] = 1'b0; had_prev[i] = 1'b0;
        end
    end

    always @(negedge clk_50m) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n === 1'b1 && rst_prev === 1'b1 && ck_d === 1'b0) begin
                checks++;
                if (txv[i] !== txp[i]) begin
                    errors++;
                    $display("FAIL tx_stable inst %0d: tx went %b -> %b without clken", i, txp[i], txv[i]);
                end
            end
            if (rst_n !== 1'b1) begin
                ph[i] = 0; gap[i] = 0; had_prev[i] = 1'b0;
            end else if (ck_d === 1'b1) begin
                case (ph[i])
                    0: begin
                        if (txv[i] === 1'b0) begin
                            if (had_prev[i]) begin
                                checks++;
                                if (chk_gap[i] ? (gap[i] != stops_of(i)) : (gap[i] < stops_of(i))) begin
                                    errors++;
                                    $display("FAIL frame_gap inst %0d: %0d high periods, required %0d", i, gap[i], stops_of(i));
                                end
                            end
                            ph[i] = 1; bc[i] = 0; rx[i] = '0;
                        end else begin
                            gap[i]++;
                        end
                    end
                    1: begin
                        rx[i][bc[i]] = txv[i];
                        bc[i]++;
                        if (bc[i] == 8) begin
                            if (par_of(i) != 0) ph[i] = 2;
                            else finish_frame(i);
                        end
                    end
                    default: begin
                        last_par[i] = txv[i];
                        checks++;
                        if (txv[i] !== ((^rx[i]) ^ (par_of(i) == 2))) begin
                            errors++;
                            $display("FAIL parity_model inst %0d: got %b for data 0x%02h", i, txv[i], rx[i]);
                        end
                        finish_frame(i);
                    end
                endcase
            end
            txp[i] = txv[i];
            if (ovf[i] === 1'b1) ovf_cnt[i]++;
        end
        rst_prev = rst_n;
    end

    task automatic tick();
        @(negedge clk_50m);
        #1;
    endtask

    task automatic write_byte(input int i, input logic [7:0] d, input bit push);
        exp_t e;
        din[i] = d;
        wen[i] = 1'b1;
        tick();
        wen[i] = 1'b0;
        if (push) begin
            e.inst = i;
            e.data = d;
            sb.push_back(e);
        end
    endtask

    task automatic wait_frames(input int i, input int target);
        int n = 0;
        while (frames[i] < target && n < 4000) begin
            tick();
            n++;
        end
        checks++;
        if (frames[i] < target) begin
            errors++;
            $display("FAIL frame_timeout inst %0d: %0d frames, required %0d", i, frames[i], target);
        end
    endtask

    task automatic wait_idle(input int i);
        int n = 0;
        while ((busy[i] !== 1'b0 || cnt[i] !== 3'd0) && n < 4000) begin
            tick();
            n++;
        end
        checks++;
        if (busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout inst %0d: tx_busy %b, required 0", i, busy[i]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wen[i] = 1'b0;
            din[i] = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks += 5;
            if (txv[i] !== 1'b1)  begin errors++; $display("FAIL reset_tx inst %0d: %b, required 1", i, txv[i]); end
            if (busy[i] !== 1'b0) begin errors++; $display("FAIL reset_busy inst %0d: %b, required 0", i, busy[i]); end
            if (full[i] !== 1'b0) begin errors++; $display("FAIL reset_full inst %0d: %b, required 0", i, full[i]); end
            if (ovf[i] !== 1'b0)  begin errors++; $display("FAIL reset_overflow inst %0d: %b, required 0", i, ovf[i]); end
            if (cnt[i] !== 3'd0)  begin errors++; $display("FAIL reset_count inst %0d: %0d, required 0", i, cnt[i]); end
        end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_frame();
        logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic got_bits [10];
        logic prev_busy;
        int   n = 0;
        int   t = 0;
        int   base = frames[0];
        write_byte(0, 8'hA5, 1'b1);
        checks += 2;
        if (cnt[0] !== 3'd1)  begin errors++; $display("FAIL latency_count: %0d, required 1", cnt[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL latency_busy_early: %b, required 0", busy[0]); end
        prev_busy = busy[0];
        tick();
        checks += 2;
        if (busy[0] !== 1'b1) begin errors++; $display("FAIL latency_busy: %b, required 1", busy[0]); end
        if (cnt[0] !== 3'd0)  begin errors++; $display("FAIL latency_pop_count: %0d, required 0", cnt[0]); end
        while (t < 1000 && !(busy[0] === 1'b0 && n > 0)) begin
            if (ck_d === 1'b1 && prev_busy === 1'b1) begin
                if (n < 10) got_bits[n] = txv[0];
                n++;
            end
            prev_busy = busy[0];
            tick();
            t++;
        end
        if (ck_d === 1'b1 && prev_busy === 1'b1) begin
            if (n < 10) got_bits[n] = txv[0];
            n++;
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("FAIL busy_periods: %0d, required 10", n);
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (got_bits[k] !== exp_bits[k]) begin
                    errors++;
                    $display("FAIL frame_bit %0d: %b, required %b", k, got_bits[k], exp_bits[k]);
                end
            end
        end
        wait_frames(0, base + 1);
    endtask

    task automatic test_parity();
        int b1 = frames[1];
        int b2 = frames[2];
        write_byte(1, 8'h07, 1'b1);
        wait_frames(1, b1 + 1);
        checks++;
        if (last_par[1] !== 1'b1) begin errors++; $display("FAIL parity_even_07: %b, required 1", last_par[1]); end
        write_byte(2, 8'h07, 1'b1);
        wait_frames(2, b2 + 1);
        checks++;
        if (last_par[2] !== 1'b0) begin errors++; $display("FAIL parity_odd_07: %b, required 0", last_par[2]); end
        wait_idle(1);
        write_byte(1, 8'h00, 1'b1);
        wait_frames(1, b1 + 2);
        checks++;
        if (last_par[1] !== 1'b0) begin errors++; $display("FAIL parity_even_00: %b, required 0", last_par[1]); end
        wait_idle(1);
        wait_idle(2);
    endtask

    task automatic test_burst_overflow();
        logic [2:0] exp_cnt [6] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        exp_t e;
        int   base = frames[0];
        int   ovf0 = ovf_cnt[0];
        wait_idle(0);
        chk_gap[0] = 1'b1;
        had_prev[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            e.inst = 0;
            e.data = 8'h11 + 8'(k);
            sb.push_back(e);
        end
        wen[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din[0] = 8'h11 + 8'(k);
            tick();
            checks += 3;
            if (cnt[0] !== exp_cnt[k]) begin errors++; $display("FAIL burst_count %0d: %0d, required %0d", k, cnt[0], exp_cnt[k]); end
            if (full[0] !== (k >= 4)) begin errors++; $display("FAIL burst_full %0d: %b, required %b", k, full[0], k >= 4); end
            if (ovf[0] !== (k == 5))  begin errors++; $display("FAIL burst_overflow %0d: %b, required %b", k, ovf[0], k == 5); end
        end
        wen[0] = 1'b0;
        tick();
        checks++;
        if (ovf[0] !== 1'b0) begin errors++; $display("FAIL overflow_pulse_width: %b, required 0", ovf[0]); end
        wait_frames(0, base + 5);
        checks++;
        if (ovf_cnt[0] - ovf0 != 1) begin errors++; $display("FAIL overflow_pulses: %0d, required 1", ovf_cnt[0] - ovf0); end
        wait_idle(0);
        chk_gap[0] = 1'b0;
    endtask

    task automatic test_two_stop();
        int base = frames[1];
        int n = 0;
        chk_gap[1] = 1'b1;
        had_prev[1] = 1'b0;
        write_byte(1, 8'h3C, 1'b1);
        write_byte(1, 8'h3C, 1'b1);
        wait_frames(1, base + 2);
        while (busy[1] !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (gap[1] != 2) begin errors++; $display("FAIL final_stop_periods: %0d, required 2", gap[1]); end
        chk_gap[1] = 1'b0;
    endtask

    task automatic test_wrap_around();
        int base = frames[0];
        int ovf0 = ovf_cnt[0];
        for (int k = 0; k < 10; k++) begin
            int n = 0;
            while (cnt[0] >= 3'd3 && n < 400) begin
                tick();
                n++;
            end
            write_byte(0, 8'($urandom_range(0, 255)), 1'b1);
        end
        wait_frames(0, base + 10);
        checks++;
        if (ovf_cnt[0] != ovf0) begin errors++; $display("FAIL wrap_overflow: %0d pulses, required 0", ovf_cnt[0] - ovf0); end
        wait_idle(0);
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        int base;
        write_byte(0, 8'h00, 1'b0);
        write_byte(0, 8'h55, 1'b0);
        write_byte(0, 8'h66, 1'b0);
        while (!(ph[0] == 1 && bc[0] >= 3) && n < 400) begin
            tick();
            n++;
        end
        checks += 2;
        if (cnt[0] !== 3'd2) begin errors++; $display("FAIL pre_reset_count: %0d, required 2", cnt[0]); end
        if (txv[0] !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: %b, required 0", txv[0]); end
        @(posedge clk_50m);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (txv[0] !== 1'b1)  begin errors++; $display("FAIL async_reset_tx: %b, required 1", txv[0]); end
        if (cnt[0] !== 3'd0)  begin errors++; $display("FAIL async_reset_count: %0d, required 0", cnt[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL async_reset_busy: %b, required 0", busy[0]); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        base = frames[0];
        write_byte(0, 8'h5A, 1'b1);
        wait_frames(0, base + 1);
        wait_idle(0);
        repeat (40) tick();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_burst_overflow();
        test_two_stop();
        test_wrap_around();
        test_reset_mid_frame();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
